// File: rtl/mem_loader.sv
// rtl/mem_loader.sv - host command-stream loader/dumper/runner for CPU external memory ports
//
// Purpose: accepts 32-bit header/address/data words from a host, writes images
// into instruction or data memory, dumps data (optionally instruction) memory
// onto a response stream, and runs the CPU for N cycles via cpu_enable.
//
// Optional feature macro: MEM_LOADER_IMEM_DUMP_EN
//   defined   - header bit 29 selects the DUMP source (1 = instruction memory)
//   undefined - DUMP always reads data memory and ren_ext is tied to 0
//
// Ports:
//   clk, arst                  clock, asynchronous active-high reset
//   cmd_valid/cmd_ready/cmd_data   command stream in (header, address, data)
//   rsp_valid/rsp_ready/rsp_data   dump stream out
//   addr_ext, wdata_ext, wen_ext, ren_ext, rdata_ext           instruction memory
//   addr_ext_2, wdata_ext_2, wen_ext_2, ren_ext_2, rdata_ext_2 data memory
//   cpu_enable                 CPU enable during RUN
//   busy                       state is not IDLE
//   done                       one-cycle pulse when a command completes

module mem_loader #(
    parameter int unsigned ADDR_STEP = 4
) (
    input  logic        clk,
    input  logic        arst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [31:0] cmd_data,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_data,
    output logic [31:0] addr_ext,
    output logic [31:0] wdata_ext,
    output logic        wen_ext,
    output logic        ren_ext,
    input  logic [31:0] rdata_ext,
    output logic [31:0] addr_ext_2,
    output logic [31:0] wdata_ext_2,
    output logic        wen_ext_2,
    output logic        ren_ext_2,
    input  logic [31:0] rdata_ext_2,
    output logic        cpu_enable,
    output logic        busy,
    output logic        done
);

    localparam logic [31:0] STEP = 32'(ADDR_STEP);

    localparam logic [1:0] OP_LOAD_I = 2'b00;
    localparam logic [1:0] OP_LOAD_D = 2'b01;
    localparam logic [1:0] OP_DUMP   = 2'b10;
    localparam logic [1:0] OP_RUN    = 2'b11;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LOAD,
        S_DUMP_RD,
        S_DUMP_CAP,
        S_DUMP_SEND,
        S_RUN,
        S_FIN
    } state_t;

    state_t      state;
    state_t      next_state;

    logic [1:0]  op;
    logic [15:0] cnt;        // words or cycles still to go
    logic        sel_imem;   // current command targets instruction memory
    logic [31:0] ptr;        // next address to be used
    logic [31:0] addr_q;
    logic [31:0] wdata_q;
    logic        wen_q;
    logic [31:0] rsp_data_q;
    logic        rsp_valid_q;
    logic        rd_en;

    logic        accept;
    logic [1:0]  hdr_op;
    logic [15:0] hdr_n;
    logic        hdr_imem;

    assign accept = cmd_valid && cmd_ready;
    assign hdr_op = cmd_data[31:30];
    assign hdr_n  = cmd_data[15:0];

`ifdef MEM_LOADER_IMEM_DUMP_EN
    assign hdr_imem = (hdr_op == OP_LOAD_I) || ((hdr_op == OP_DUMP) && cmd_data[29]);
    logic [12:0] unused_hdr;
    assign unused_hdr = cmd_data[28:16];
`else
    assign hdr_imem = (hdr_op == OP_LOAD_I);
    logic [13:0] unused_hdr;
    assign unused_hdr = cmd_data[29:16];
`endif

    // State register
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (accept) begin
                    if (hdr_op == OP_RUN) begin
                        next_state = (hdr_n == 16'd0) ? S_FIN : S_RUN;
                    end else begin
                        next_state = S_ADDR;
                    end
                end
            end
            S_ADDR: begin
                if (accept) begin
                    if (cnt == 16'd0) begin
                        next_state = S_FIN;
                    end else if (op == OP_DUMP) begin
                        next_state = S_DUMP_RD;
                    end else begin
                        next_state = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                if (accept && (cnt == 16'd1)) begin
                    next_state = S_FIN;
                end
            end
            S_DUMP_RD:  next_state = S_DUMP_CAP;
            S_DUMP_CAP: next_state = S_DUMP_SEND;
            S_DUMP_SEND: begin
                if (rsp_ready) begin
                    next_state = (cnt == 16'd1) ? S_FIN : S_DUMP_RD;
                end
            end
            S_RUN: begin
                if (cnt == 16'd1) begin
                    next_state = S_FIN;
                end
            end
            // The last write of a LOAD is still on the bus when FIN is
            // entered; linger one cycle so done never overlaps a write.
            S_FIN: begin
                if (!wen_q) begin
                    next_state = S_IDLE;
                end
            end
            default: next_state = S_IDLE;
        endcase
    end

    // State-decoded outputs
    always_comb begin
        cmd_ready  = 1'b0;
        cpu_enable = 1'b0;
        busy       = (state != S_IDLE);
        done       = 1'b0;
        rd_en      = 1'b0;
        case (state)
            S_IDLE, S_ADDR, S_LOAD: cmd_ready  = 1'b1;
            S_DUMP_RD:              rd_en      = 1'b1;
            S_RUN:                  cpu_enable = 1'b1;
            S_FIN:                  done       = !wen_q;
            default: ;
        endcase
    end

    // Datapath: counters, address pointer, write and response registers
    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            op          <= OP_LOAD_I;
            cnt         <= 16'd0;
            sel_imem    <= 1'b0;
            ptr         <= 32'd0;
            addr_q      <= 32'd0;
            wdata_q     <= 32'd0;
            wen_q       <= 1'b0;
            rsp_data_q  <= 32'd0;
            rsp_valid_q <= 1'b0;
        end else begin
            wen_q <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        op       <= hdr_op;
                        cnt      <= hdr_n;
                        sel_imem <= hdr_imem;
                    end
                end
                S_ADDR: begin
                    if (accept) begin
                        ptr    <= cmd_data;
                        addr_q <= cmd_data;
                    end
                end
                S_LOAD: begin
                    if (accept) begin
                        addr_q  <= ptr;
                        wdata_q <= cmd_data;
                        wen_q   <= 1'b1;
                        ptr     <= ptr + STEP;
                        cnt     <= cnt - 16'd1;
                    end
                end
                S_DUMP_RD: begin
                    ptr <= ptr + STEP;
                end
                S_DUMP_CAP: begin
                    rsp_data_q  <= sel_imem ? rdata_ext : rdata_ext_2;
                    rsp_valid_q <= 1'b1;
                end
                S_DUMP_SEND: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        cnt         <= cnt - 16'd1;
                        addr_q      <= ptr;
                    end
                end
                S_RUN: begin
                    cnt <= cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    assign addr_ext    = addr_q;
    assign addr_ext_2  = addr_q;
    assign wdata_ext   = wdata_q;
    assign wdata_ext_2 = wdata_q;
    assign wen_ext     = wen_q && sel_imem;
    assign wen_ext_2   = wen_q && !sel_imem;
    assign ren_ext_2   = rd_en && !sel_imem;
`ifdef MEM_LOADER_IMEM_DUMP_EN
    assign ren_ext     = rd_en && sel_imem;
`else
    assign ren_ext     = 1'b0;
`endif
    assign rsp_valid   = rsp_valid_q;
    assign rsp_data    = rsp_data_q;

endmodule

// File: tb/tb_mem_loader.sv
// tb/tb_mem_loader.sv - self-checking bench for mem_loader

module tb_mem_loader;

    localparam logic [1:0] OP_LI = 2'b00;
    localparam logic [1:0] OP_LD = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;
    localparam logic [1:0] OP_RUN = 2'b11;

    logic        clk = 1'b0;
    logic        arst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [31:0] cmd_data = 32'd0;
    logic        rsp_valid;
    logic        rsp_ready = 1'b0;
    logic [31:0] rsp_data;
    logic [31:0] addr_ext, wdata_ext, rdata_ext = 32'd0;
    logic        wen_ext, ren_ext;
    logic [31:0] addr_ext_2, wdata_ext_2, rdata_ext_2 = 32'd0;
    logic        wen_ext_2, ren_ext_2;
    logic        cpu_enable, busy, done;

    mem_loader #(.ADDR_STEP(4)) dut (
        .clk(clk), .arst(arst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_data(cmd_data),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .addr_ext(addr_ext), .wdata_ext(wdata_ext), .wen_ext(wen_ext),
        .ren_ext(ren_ext), .rdata_ext(rdata_ext),
        .addr_ext_2(addr_ext_2), .wdata_ext_2(wdata_ext_2), .wen_ext_2(wen_ext_2),
        .ren_ext_2(ren_ext_2), .rdata_ext_2(rdata_ext_2),
        .cpu_enable(cpu_enable), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Memories seen by the DUT: one-cycle registered read
    logic [31:0] imem [logic [31:0]];
    logic [31:0] dmem [logic [31:0]];
    always @(posedge clk) begin
        if (wen_ext) imem[addr_ext] = wdata_ext;
        if (wen_ext_2) dmem[addr_ext_2] = wdata_ext_2;
        if (ren_ext) rdata_ext <= imem.exists(addr_ext) ? imem[addr_ext] : 32'h0;
        if (ren_ext_2) rdata_ext_2 <= dmem.exists(addr_ext_2) ? dmem[addr_ext_2] : 32'h0;
    end

    // Reference model of memory contents, built only from commands sent
    logic [31:0] ref_i [logic [31:0]];
    logic [31:0] ref_d [logic [31:0]];
    function automatic logic [31:0] ref_rd(input logic sel, input logic [31:0] a);
        if (sel) return ref_i.exists(a) ? ref_i[a] : 32'h0;
        return ref_d.exists(a) ? ref_d[a] : 32'h0;
    endfunction

    // 0 = always ready, 1 = random, 2 = held low
    int ready_mode = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            0: rsp_ready = 1'b1;
            1: rsp_ready = 1'($urandom_range(0, 1));
            default: rsp_ready = 1'b0;
        endcase
    end

    typedef struct {
        logic        mem;
        logic [31:0] addr;
        logic [31:0] data;
        int          c;
    } wr_t;

    wr_t         wr_q[$];
    logic [31:0] rsp_q[$];
    int          acc_q[$];
    logic [31:0] data_q[$];
    int en_cnt = 0, en_first = 0, done_cnt = 0, done_cyc = 0, ren_i_cnt = 0, viol = 0;
    logic        prev_hold = 1'b0;
    logic [31:0] prev_data = 32'd0;

    always @(negedge clk) begin
        if (arst) begin
            prev_hold = 1'b0;
        end else begin
            if (wen_ext) wr_q.push_back('{1'b1, addr_ext, wdata_ext, cyc});
            if (wen_ext_2) wr_q.push_back('{1'b0, addr_ext_2, wdata_ext_2, cyc});
            if (ren_ext) ren_i_cnt++;
            if (rsp_valid && rsp_ready) rsp_q.push_back(rsp_data);
            if (cpu_enable) begin
                if (en_cnt == 0) en_first = cyc;
                en_cnt++;
            end
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (32'(wen_ext) + 32'(wen_ext_2) + 32'(ren_ext) + 32'(ren_ext_2) > 1) begin
                viol++; $display("note: several memory enables at cycle %0d", cyc);
            end
            if (done && (cpu_enable || wen_ext || wen_ext_2 || rsp_valid)) begin
                viol++; $display("note: done overlaps activity at cycle %0d", cyc);
            end
            if (cpu_enable && (wen_ext || wen_ext_2 || cmd_ready)) begin
                viol++; $display("note: write or cmd_ready during run at cycle %0d", cyc);
            end
            if (prev_hold && (!rsp_valid || rsp_data !== prev_data)) begin
                viol++; $display("note: response changed before handshake at cycle %0d", cyc);
            end
            prev_hold = rsp_valid && !rsp_ready;
            prev_data = rsp_data;
        end
    end

    task automatic clear_logs();
        wr_q.delete(); rsp_q.delete(); acc_q.delete();
        en_cnt = 0; done_cnt = 0; ren_i_cnt = 0;
    endtask

    // Called and returns just after a falling edge
    task automatic send_word(input logic [31:0] d);
        int k = 0;
        cmd_valid = 1'b1;
        cmd_data = d;
        while (!cmd_ready && k < 2000) begin
            @(negedge clk);
            k++;
        end
        if (!cmd_ready) begin
            checks++; failures++;
            $display("FAIL cmd_accept_timeout actual=0 required=1");
        end else begin
            acc_q.push_back(cyc);
        end
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int k = 0;
        while (done_cnt == 0 && k < 3000) begin
            @(negedge clk);
            k++;
        end
        if (done_cnt == 0) begin
            checks++; failures++;
            $display("FAIL done_timeout actual=0 required=1");
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic run_cmd(input string nm, input logic [31:0] hdr, input logic [31:0] base,
                           input int exp_wr, input int exp_rsp, input int exp_en);
        wr_t ew[$];
        logic [31:0] er[$];
        logic [31:0] words[$];
        logic [1:0] op;
        int n;
        logic sel;
        logic [31:0] a, d;
        op = hdr[31:30];
        n = int'(hdr[15:0]);
`ifdef MEM_LOADER_IMEM_DUMP_EN
        sel = (op == OP_DUMP) && hdr[29];
`else
        sel = 1'b0;
`endif
        clear_logs();
        if (op == OP_LI || op == OP_LD) begin
            for (int i = 0; i < n; i++) begin
                d = (data_q.size() > 0) ? data_q.pop_front() : $urandom;
                a = base + 32'(i) * 32'd4;
                words.push_back(d);
                ew.push_back('{op == OP_LI, a, d, 0});
                if (op == OP_LI) ref_i[a] = d; else ref_d[a] = d;
            end
        end
        if (op == OP_DUMP) begin
            for (int i = 0; i < n; i++) er.push_back(ref_rd(sel, base + 32'(i) * 32'd4));
        end
        send_word(hdr);
        if (op != OP_RUN) send_word(base);
        foreach (words[i]) send_word(words[i]);
        wait_done();
        chk({nm, ".writes"}, 32'(wr_q.size()), 32'(exp_wr));
        for (int i = 0; i < ew.size() && i < wr_q.size(); i++) begin
            chk($sformatf("%s.wr%0d_mem", nm, i), 32'(wr_q[i].mem), 32'(ew[i].mem));
            chk($sformatf("%s.wr%0d_addr", nm, i), wr_q[i].addr, ew[i].addr);
            chk($sformatf("%s.wr%0d_data", nm, i), wr_q[i].data, ew[i].data);
        end
        chk({nm, ".rsp_count"}, 32'(rsp_q.size()), 32'(exp_rsp));
        for (int i = 0; i < er.size() && i < rsp_q.size(); i++)
            chk($sformatf("%s.rsp%0d", nm, i), rsp_q[i], er[i]);
        chk({nm, ".en_cycles"}, 32'(en_cnt), 32'(exp_en));
        chk({nm, ".done_pulses"}, 32'(done_cnt), 32'd1);
        chk({nm, ".idle_after"}, {30'd0, busy, cmd_ready}, 32'd1);
    endtask

    typedef struct {
        logic [31:0] hdr;
        logic [31:0] base;
        int          exp_wr;
        int          exp_rsp;
        int          exp_en;
    } vec_t;

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[10];
        logic [1:0] rop;
        int rn, k;
        logic [31:0] rbase, rhdr;

        tbl[0] = '{32'h4000_0004, 32'h0000_0200, 4, 0, 0};
        tbl[1] = '{32'h0000_0002, 32'h0000_0040, 2, 0, 0};
        tbl[2] = '{32'h4000_0000, 32'h0000_0300, 0, 0, 0};
        tbl[3] = '{32'h4000_0002, 32'hFFFF_FFFC, 2, 0, 0};
        tbl[4] = '{32'h8000_0004, 32'h0000_0200, 0, 4, 0};
        tbl[5] = '{32'h8000_0000, 32'h0000_0200, 0, 0, 0};
        tbl[6] = '{32'hC000_0005, 32'h0000_0000, 0, 0, 5};
        tbl[7] = '{32'hC000_0000, 32'h0000_0000, 0, 0, 0};
        tbl[8] = '{32'h8000_0001, 32'hFFFF_FFFC, 0, 1, 0};
        tbl[9] = '{32'h8000_0003, 32'h0000_0204, 0, 3, 0};

        // Reset state
        repeat (3) @(negedge clk);
        chk("reset.cmd_ready", 32'(cmd_ready), 32'd1);
        chk("reset.ctrl", {24'd0, busy, done, cpu_enable, wen_ext, wen_ext_2, ren_ext, ren_ext_2, rsp_valid}, 32'd0);
        chk("reset.addr", addr_ext_2, 32'd0);
        chk("reset.rsp_data", rsp_data, 32'd0);
        arst = 1'b0;
        @(negedge clk);

        // Program load with write timing
        data_q = '{32'h2001_0005, 32'h2002_0007, 32'h0022_1820};
        run_cmd("load_i", 32'h0000_0003, 32'h0, 3, 0, 0);
        for (int i = 0; i < 3 && i < wr_q.size(); i++)
            chk($sformatf("load_i.wr%0d_cycle", i), 32'(wr_q[i].c), 32'(acc_q[2 + i] + 1));
        if (wr_q.size() == 3) chk("load_i.done_cycle", 32'(done_cyc), 32'(wr_q[2].c + 1));

        // Dump under backpressure
        data_q = '{32'hDEAD_BEEF, 32'h1234_5678};
        run_cmd("load_d", 32'h4000_0002, 32'h100, 2, 0, 0);
        clear_logs();
        ready_mode = 2;
        @(negedge clk);
        send_word(32'h8000_0002);
        send_word(32'h0000_0100);
        k = 0;
        while (!rsp_valid && k < 100) begin @(negedge clk); k++; end
        repeat (5) @(negedge clk);
        chk("bp.valid_held", 32'(rsp_valid), 32'd1);
        chk("bp.data_held", rsp_data, 32'hDEAD_BEEF);
        ready_mode = 0;
        wait_done();
        chk("bp.rsp_count", 32'(rsp_q.size()), 32'd2);
        if (rsp_q.size() == 2) begin
            chk("bp.rsp0", rsp_q[0], 32'hDEAD_BEEF);
            chk("bp.rsp1", rsp_q[1], 32'h1234_5678);
        end

        // RUN 10 cycles
        run_cmd("run10", 32'hC000_000A, 32'h0, 0, 0, 10);
        chk("run10.first_en", 32'(en_first), 32'(acc_q[0] + 1));
        chk("run10.done_cycle", 32'(done_cyc), 32'(acc_q[0] + 11));

        // Zero-count load completes right after the address word
        run_cmd("load0", 32'h4000_0000, 32'h300, 0, 0, 0);
        chk("load0.done_cycle", 32'(done_cyc), 32'(acc_q[1] + 1));

        // Table-driven vectors
        for (int i = 0; i < 10; i++)
            run_cmd($sformatf("tbl%0d", i), tbl[i].hdr, tbl[i].base, tbl[i].exp_wr, tbl[i].exp_rsp, tbl[i].exp_en);

`ifdef MEM_LOADER_IMEM_DUMP_EN
        run_cmd("imem_dump", 32'hA000_0001, 32'h4, 0, 1, 0);
        chk("imem_dump.ren_pulses", 32'(ren_i_cnt), 32'd1);
`endif

        // Randomized commands against the reference model
        run_cmd("preload", 32'h4000_0010, 32'h1000, 16, 0, 0);
        ready_mode = 1;
        for (int i = 0; i < 40; i++) begin
            rop = 2'($urandom_range(0, 3));
            rn = $urandom_range(0, 6);
            rbase = (rop == OP_LI) ? 32'h2000 + 32'($urandom_range(0, 8)) * 4
                                   : 32'h1000 + 32'($urandom_range(0, 9)) * 4;
            rhdr = {rop, 1'b0, 13'($urandom), 16'(rn)};
            run_cmd($sformatf("rnd%0d", i), rhdr, rbase,
                    (rop == OP_LI || rop == OP_LD) ? rn : 0,
                    (rop == OP_DUMP) ? rn : 0,
                    (rop == OP_RUN) ? rn : 0);
        end
        ready_mode = 0;

        // Reset in the middle of a long RUN
        clear_logs();
        send_word(32'hC000_0064);
        k = 0;
        while (en_cnt < 40 && k < 200) begin @(negedge clk); k++; end
        chk("rst_run.reached_40", 32'(en_cnt), 32'd40);
        arst = 1'b1;
        #1;
        chk("rst_run.enable_async", 32'(cpu_enable), 32'd0);
        chk("rst_run.ready_in_reset", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        arst = 1'b0;
        @(negedge clk);
        chk("rst_run.idle_after", {29'd0, busy, cmd_ready, cpu_enable}, 32'd2);
        run_cmd("post_reset", 32'hC000_0003, 32'h0, 0, 0, 3);

        chk("invariants", 32'(viol), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_loader.md
# mem_loader

Host-side initiator for the CPU's external memory access ports. It accepts a 32-bit command stream from a test host, writes program and data images into instruction and data memory, and reads data memory back out as a response stream. It also runs the CPU for a programmed number of cycles by driving `enable`. It sits outside `cpu`, driving `addr_ext*`, `wen_ext*`, `ren_ext*` and `wdata_ext*`, consuming `rdata_ext*`, and owning the CPU `enable` line.

## Interface
- `ADDR_STEP`, default 4: byte increment between consecutive words (memories are byte-addressed, word-wide).
- `clk` input 1: single clock; all logic on rising edge.
- `arst` input 1: reset, asynchronous, active-high.
- `cmd_valid` input 1: command/data word valid.
- `cmd_ready` output 1: block accepts `cmd_data` on `cmd_valid && cmd_ready`.
- `cmd_data` input 32: header, address or data word.
- `rsp_valid` output 1: dump word valid.
- `rsp_ready` input 1: host accepts `rsp_data`.
- `rsp_data` output 32: dumped memory word.
- `addr_ext`, `wdata_ext` output 32: instruction-memory external address and write data.
- `wen_ext`, `ren_ext` output 1: instruction-memory external write and read enables.
- `rdata_ext` input 32: instruction-memory external read data.
- `addr_ext_2`, `wdata_ext_2` output 32: data-memory external address and write data.
- `wen_ext_2`, `ren_ext_2` output 1: data-memory external write and read enables.
- `rdata_ext_2` input 32: data-memory external read data.
- `cpu_enable` output 1: drives CPU `enable`.
- `busy` output 1: state is not IDLE.
- `done` output 1: one-cycle pulse when a command completes.

## Operation
- Header word layout:
  - `[31:30]` op: 00 LOAD_I, 01 LOAD_D, 10 DUMP, 11 RUN.
  - `[29]` memory select, DUMP only: 0 = data memory, 1 = instruction memory.
  - `[28:16]` reserved, ignored.
  - `[15:0]` count N.
- LOAD_I / LOAD_D: header, then base address word, then N data words.
  - Data word k is written to `base + k*ADDR_STEP`. Address arithmetic is 32-bit and wraps modulo 2^32.
- DUMP: header, then base address word. The block returns N words on the response stream, in address order.
- RUN: header only. `cpu_enable` is high for exactly N cycles.
- N = 0:
  - LOAD and DUMP still consume the address word, perform no memory access, then pulse `done`.
  - RUN pulses `done` with no enable cycles.
- States and transitions:
  - IDLE: `cmd_ready` = 1. A header goes to ADDR for LOAD/DUMP, or to RUN for RUN.
  - ADDR: `cmd_ready` = 1. Latch base address. Go to LOAD or DUMP_RD, or to FIN if N = 0.
  - LOAD: `cmd_ready` = 1. Each accepted word issues one write. Go to FIN after word N.
  - DUMP_RD: issue one read. Go to DUMP_CAP.
  - DUMP_CAP: capture `rdata` into the `rsp_data` register and set `rsp_valid`. Go to DUMP_SEND.
  - DUMP_SEND: hold `rsp_valid`/`rsp_data` stable until `rsp_ready`. Then go to DUMP_RD, or to FIN after word N.
  - RUN: decrement the cycle counter. Go to FIN when it expires.
  - FIN: `done` = 1. Return to IDLE.
- `cmd_ready` = 0 in every state other than IDLE, ADDR and LOAD. The block never writes memory while `cpu_enable` is high.
- At most one of the two memories' enables is active in any cycle. `wen` and `ren` are never both high.

## Timing
- While `arst` is asserted: state IDLE; all outputs 0 except `cmd_ready` = 1. `cpu_enable` falls asynchronously with `arst`.
- Reset mid-operation aborts the command. No partial-state recovery; the host re-sends the whole command.
- Write latency: a data word accepted in cycle t drives `addr`/`wdata`/`wen` registered in cycle t+1, with `wen` high for exactly that one cycle. Back-to-back accepted words give back-to-back writes.
- Read: `ren` high for one cycle (DUMP_RD). Memory `rdata` is valid in the following cycle (DUMP_CAP).
  - Each dumped word takes a minimum of 3 cycles when `rsp_ready` is held high.
- RUN: a header accepted in cycle t gives `cpu_enable` high in cycles t+1 … t+N, and `done` in cycle t+N+1.
- `done` is never asserted in the same cycle as `cpu_enable`, `wen*` or `rsp_valid`.
- `rsp_valid` may only drop after a handshake cycle.

## Configuration
- `MEM_LOADER_IMEM_DUMP_EN`
  - Defined: header bit 29 selects the dump source; instruction-memory reads use `ren_ext`/`rdata_ext`.
  - Undefined: bit 29 is ignored, DUMP always reads data memory, and `ren_ext` is tied to 0.

## Test plan
- Load: LOAD_I header `0x00000003`, address `0x00000000`, words `0x20010005`, `0x20020007`, `0x00221820` → `wen_ext` pulses at addresses 0x0, 0x4, 0x8 with matching data; then `done`.
- Dump under backpressure: LOAD_D 2 words `0xDEADBEEF`, `0x12345678` at `0x100`, then DUMP N = 2 at `0x100` with `rsp_ready` low for 5 cycles → `rsp_data` held at `0xDEADBEEF`, then `0x12345678`, each returned exactly once.
- RUN `0xC000000A` → `cpu_enable` high for exactly 10 cycles; `done` on the 11th; `cmd_ready` low throughout.
- Zero count and wrap: LOAD_D with N = 0 → no `wen_ext_2`, `done` after the address word. LOAD_D with N = 2 at base `0xFFFFFFFC` → writes at `0xFFFFFFFC`, then `0x00000000`.
- Reset mid-RUN: RUN N = 100, assert `arst` at enable cycle 40 → `cpu_enable` drops immediately; after release, state is IDLE and `cmd_ready` = 1.
- With `MEM_LOADER_IMEM_DUMP_EN` defined: DUMP header `0xA0000001` at address 0x4 → `ren_ext` pulses once and the instruction word is returned on `rsp_data`.
